// File: rtl/snoop_responder_pkg.sv
// rtl/snoop_responder_pkg.sv - shared MSI, bus command and address-field definitions
package snoop_responder_pkg;

    localparam int ADDR_W   = 32;
    localparam int CMD_W    = 3;
    localparam int NUM_WAYS = 4;
    localparam int WAY_W    = 2;
    localparam int STATE_W  = 2;
    localparam int TAG_W    = 23;
    localparam int META_W   = STATE_W + TAG_W;
    localparam int LINE_W   = 256;
    localparam int SET_W    = 4;

    // Address slicing shared with the bus arbiter
    localparam int TAG_HI   = 31;
    localparam int TAG_LO   = 9;
    localparam int SET_HI   = 8;
    localparam int SET_LO   = 5;

    typedef enum logic [STATE_W-1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b11
    } msi_e;

    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_BUS_RD   = 2'd1,
        CMD_BUS_RDX  = 2'd2,
        CMD_BUS_UPGR = 2'd3
    } bus_cmd_e;

    // Unused encodings on the 3-bit bus collapse to NONE
    function automatic bus_cmd_e decode_cmd(input logic [CMD_W-1:0] raw);
        bus_cmd_e c;
        case (raw)
            3'd1:    c = CMD_BUS_RD;
            3'd2:    c = CMD_BUS_RDX;
            3'd3:    c = CMD_BUS_UPGR;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/snoop_responder_tag_cmp.sv
// rtl/snoop_responder_tag_cmp.sv - 4-way tag compare with lowest-way priority
module snoop_tag_cmp
    import snoop_responder_pkg::*;
(
    input  logic [NUM_WAYS-1:0][META_W-1:0] meta,
    input  logic [TAG_W-1:0]                tag,
    output logic [NUM_WAYS-1:0]             hit_vec,
    output logic [WAY_W-1:0]                win_way,
    output msi_e                            win_state
);

    // Per-way hit, then scan downward so the lowest hitting way is left standing
    always_comb begin
        hit_vec   = '0;
        win_way   = '0;
        win_state = MSI_I;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = (meta[w][TAG_W-1:0] == tag) &&
                         (meta[w][META_W-1 -: STATE_W] != MSI_I);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                win_way   = WAY_W'(w);
                win_state = msi_e'(meta[w][META_W-1 -: STATE_W]);
            end
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - MSI snoop responder for one cache's tag/data array
module snoop_responder
    import snoop_responder_pkg::*;
#(
    parameter int CORE_ID = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W-1:0]               cmd_addr,
    input  logic [CMD_W-1:0]                cmd_command,
    input  logic                            cmd_src,
    output logic                            arr_req,
    input  logic                            arr_gnt,
    output logic [SET_W-1:0]                arr_set,
    input  logic [NUM_WAYS-1:0][META_W-1:0] meta_rdata,
    input  logic [NUM_WAYS-1:0][LINE_W-1:0] data_rdata,
    output logic [NUM_WAYS-1:0]             meta_we,
    output logic [META_W-1:0]               meta_wdata,
    output logic                            resp_valid,
    output logic                            resp_hit,
    output logic                            resp_flush,
    output logic [LINE_W-1:0]               resp_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_READ,
        ST_COMPARE,
        ST_UPDATE,
        ST_WAIT_CLR
    } state_e;

    state_e                 state_q, state_d;
    bus_cmd_e               cmd_q, cmd_d;
    logic [ADDR_W-1:SET_LO] addr_q, addr_d;
    logic [WAY_W-1:0]       way_q, way_d;
    msi_e                   new_state_q, new_state_d;

    logic [NUM_WAYS-1:0]    hit_vec;
    logic                   any_hit;
    logic [WAY_W-1:0]       win_way;
    msi_e                   win_state;
    bus_cmd_e               live_cmd;
    logic [NUM_WAYS-1:0]    meta_we_raw;
    logic                   unused_addr_lsbs;

    // Line-offset bits never matter to a snoop
    assign unused_addr_lsbs = ^cmd_addr[SET_LO-1:0];
    assign live_cmd         = decode_cmd(cmd_command);
    assign any_hit          = |hit_vec;

    snoop_tag_cmp u_tag_cmp (
        .meta      (meta_rdata),
        .tag       (addr_q[TAG_HI:TAG_LO]),
        .hit_vec   (hit_vec),
        .win_way   (win_way),
        .win_state (win_state)
    );

    // State and captured-command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NONE;
            addr_q      <= '0;
            way_q       <= '0;
            new_state_q <= MSI_I;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            new_state_q <= new_state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        way_d       = way_q;
        new_state_d = new_state_q;
        arr_req     = 1'b0;
        arr_set     = '0;
        meta_we_raw = '0;
        meta_wdata  = '0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_flush  = 1'b0;
        resp_data   = '0;
        case (state_q)
            ST_IDLE: begin
                if (live_cmd != CMD_NONE && cmd_src != 1'(CORE_ID)) begin
                    cmd_d   = live_cmd;
                    addr_d  = cmd_addr[ADDR_W-1:SET_LO];
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (live_cmd == CMD_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    arr_req = 1'b1;
                    if (arr_gnt) begin
                        arr_set = addr_q[SET_HI:SET_LO];
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (live_cmd == CMD_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    arr_req = 1'b1;
                    arr_set = addr_q[SET_HI:SET_LO];
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                resp_valid  = 1'b1;
                resp_hit    = any_hit;
                resp_flush  = any_hit && (win_state == MSI_M);
                resp_data   = any_hit ? data_rdata[win_way] : '0;
                way_d       = win_way;
                // Every write demotes: reads leave a shared copy, the rest invalidate
                new_state_d = (cmd_q == CMD_BUS_RD) ? MSI_S : MSI_I;
                if (!any_hit || (cmd_q == CMD_BUS_RD && win_state == MSI_S)) begin
                    state_d = ST_WAIT_CLR;
                end else begin
                    arr_req = 1'b1;
                    arr_set = addr_q[SET_HI:SET_LO];
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                arr_req     = 1'b1;
                arr_set     = addr_q[SET_HI:SET_LO];
                meta_we_raw = NUM_WAYS'(1) << way_q;
                meta_wdata  = {new_state_q, addr_q[TAG_HI:TAG_LO]};
                state_d     = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (live_cmd == CMD_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset landing in UPDATE must not let the write strobe through that edge
    assign meta_we = rst ? '0 : meta_we_raw;

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - randomized self-checking bench with a line-level MSI model
module tb_snoop_responder;
    import snoop_responder_pkg::*;

    localparam int TB_CORE = 0;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [ADDR_W-1:0]               cmd_addr;
    logic [CMD_W-1:0]                cmd_command;
    logic                            cmd_src;
    logic                            arr_req;
    logic                            arr_gnt;
    logic [SET_W-1:0]                arr_set;
    logic [NUM_WAYS-1:0][META_W-1:0] meta_rdata;
    logic [NUM_WAYS-1:0][LINE_W-1:0] data_rdata;
    logic [NUM_WAYS-1:0]             meta_we;
    logic [META_W-1:0]               meta_wdata;
    logic                            resp_valid;
    logic                            resp_hit;
    logic                            resp_flush;
    logic [LINE_W-1:0]               resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    snoop_responder #(.CORE_ID(TB_CORE)) dut (
        .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_command(cmd_command),
        .cmd_src(cmd_src), .arr_req(arr_req), .arr_gnt(arr_gnt), .arr_set(arr_set),
        .meta_rdata(meta_rdata), .data_rdata(data_rdata), .meta_we(meta_we),
        .meta_wdata(meta_wdata), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_flush(resp_flush), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    // Array port arbiter: grant after gnt_delay cycles of request, held while requested
    int gnt_delay = 0;
    int req_cnt   = 0;
    always @(posedge clk) begin
        if (!arr_req) req_cnt <= 0;
        else          req_cnt <= req_cnt + 1;
    end
    assign arr_gnt = arr_req && (req_cnt >= gnt_delay);

    // Cache array: 1-cycle read, write on meta_we, preload port for the bench
    logic [META_W-1:0] mem_meta [16][NUM_WAYS];
    logic [LINE_W-1:0] mem_data [16][NUM_WAYS];
    logic [META_W-1:0] exp_meta [16][NUM_WAYS];
    logic                            pl_en = 1'b0;
    logic [SET_W-1:0]                pl_set;
    logic [NUM_WAYS-1:0][META_W-1:0] pl_vals;

    always @(posedge clk) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            meta_rdata[w] <= mem_meta[arr_set][w];
            data_rdata[w] <= mem_data[arr_set][w];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (meta_we[w]) mem_meta[arr_set][w] = meta_wdata;
            if (pl_en)      mem_meta[pl_set][w]  = pl_vals[w];
        end
    end

    task automatic check(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [META_W-1:0] mk(input logic [1:0] st, input logic [TAG_W-1:0] t);
        return {st, t};
    endfunction

    task automatic load_set(input logic [SET_W-1:0] s, input logic [NUM_WAYS-1:0][META_W-1:0] vals);
        for (int w = 0; w < NUM_WAYS; w++) begin
            exp_meta[s][w] = vals[w];
            mem_data[s][w] = {8{$urandom()}};
        end
        pl_set  = s;
        pl_vals = vals;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // One snoop: the model derives the outcome from MSI rules, then the DUT is observed
    task automatic txn(input logic [ADDR_W-1:0] a, input logic [2:0] c, input logic s, input int d);
        logic [SET_W-1:0]  set;
        logic [TAG_W-1:0]  tag;
        logic              act, found, e_hit, e_flush, e_write;
        logic [1:0]        st, e_ns;
        int                hw;
        logic [LINE_W-1:0] e_data;
        int                nresp, nwr, rk, wk;
        logic              req_seen, r_hit, r_flush;
        logic [LINE_W-1:0] r_data;
        logic [3:0]        r_we;
        logic [24:0]       r_wd;
        set   = a[SET_HI:SET_LO];
        tag   = a[TAG_HI:TAG_LO];
        act   = (c >= 3'd1 && c <= 3'd3) && (s != 1'(TB_CORE));
        found = 1'b0; hw = 0; st = 2'b00;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && exp_meta[set][w][TAG_W-1:0] == tag && exp_meta[set][w][24:23] != 2'b00) begin
                found = 1'b1; hw = w; st = exp_meta[set][w][24:23];
            end
        end
        e_hit   = act && found;
        e_flush = e_hit && st == 2'b11;
        e_data  = e_hit ? mem_data[set][hw] : '0;
        e_write = e_hit && !(c == 3'd1 && st == 2'b01);
        e_ns    = (c == 3'd1) ? 2'b01 : 2'b00;

        nresp = 0; nwr = 0; rk = 0; wk = 0; req_seen = 1'b0;
        r_hit = 1'b0; r_flush = 1'b0; r_data = '0; r_we = '0; r_wd = '0;
        cmd_addr = a; cmd_command = c; cmd_src = s; gnt_delay = d;
        for (int k = 1; k <= 12 + d; k++) begin
            @(negedge clk);
            if (arr_req) req_seen = 1'b1;
            if (resp_valid) begin
                nresp++; rk = k; r_hit = resp_hit; r_flush = resp_flush; r_data = resp_data;
            end
            if (|meta_we) begin
                nwr++; wk = k; r_we = meta_we; r_wd = meta_wdata;
            end
            if (k == 10 + d) cmd_command = 3'd0;
        end
        check("resp_count", nresp, act ? 1 : 0);
        if (act) begin
            check("resp_latency", rk, 3 + d);
            check("resp_hit", r_hit, e_hit);
            check("resp_flush", r_flush, e_flush);
            check("resp_data", r_data, e_data);
        end
        check("write_count", nwr, e_write ? 1 : 0);
        if (e_write) begin
            check("write_latency", wk, 4 + d);
            check("meta_we", r_we, 4'b0001 << hw);
            check("meta_wdata", r_wd, {e_ns, tag});
            exp_meta[set][hw] = {e_ns, tag};
        end
        check("arr_req_seen", req_seen, act);
        check("arr_req_after", arr_req, 1'b0);
        for (int w = 0; w < NUM_WAYS; w++) check("array_meta", mem_meta[set][w], exp_meta[set][w]);
    endtask

    logic [TAG_W-1:0] pool [3];
    logic [1:0]       st_pool [3];

    initial begin
        int nresp, nwr;
        logic [NUM_WAYS-1:0][META_W-1:0] v;
        logic [SET_W-1:0] rs;
        pool[0] = 23'h1234; pool[1] = 23'h00055; pool[2] = 23'h7ABCD;
        st_pool[0] = 2'b00; st_pool[1] = 2'b01; st_pool[2] = 2'b11;
        rst = 1'b1; cmd_addr = '0; cmd_command = '0; cmd_src = 1'b0; pl_set = '0; pl_vals = '0;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
                exp_meta[s][w] = '0; mem_meta[s][w] = '0; mem_data[s][w] = '0;
            end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_arr_req", arr_req, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_meta_we", meta_we, 4'b0);
        check("reset_resp_data", resp_data, '0);

        // Set 3 way 2 modified, read from the other core
        v[0] = mk(2'b01, 23'h0099); v[1] = mk(2'b11, 23'h0100); v[2] = mk(2'b11, 23'h1234); v[3] = mk(2'b00, 23'h1234);
        load_set(4'd3, v);
        txn({23'h1234, 4'd3, 5'd0}, 3'd1, 1'b1, 0);
        // Way 2 now shared: a second read must not write, RDX invalidates
        txn({23'h1234, 4'd3, 5'd4}, 3'd1, 1'b1, 0);
        txn({23'h1234, 4'd3, 5'd8}, 3'd2, 1'b1, 0);
        // Miss in every way
        txn({23'h3333, 4'd3, 5'd0}, 3'd2, 1'b1, 0);
        // Two shared hits: lowest way wins, upgrade invalidates
        v[0] = mk(2'b00, 23'h0055); v[1] = mk(2'b01, 23'h0055); v[2] = mk(2'b11, 23'h0001); v[3] = mk(2'b01, 23'h0055);
        load_set(4'd7, v);
        txn({23'h0055, 4'd7, 5'd0}, 3'd3, 1'b1, 0);
        txn({23'h0055, 4'd7, 5'd0}, 3'd3, 1'b1, 0);
        // Own-source command is ignored; delayed grant shifts the response
        txn({23'h0001, 4'd7, 5'd0}, 3'd2, 1'b0, 0);
        txn({23'h0001, 4'd7, 5'd0}, 3'd1, 1'b1, 5);

        // Command withdrawn while waiting for the grant
        v[0] = mk(2'b11, 23'h00AA); v[1] = '0; v[2] = '0; v[3] = '0;
        load_set(4'd9, v);
        cmd_addr = {23'h00AA, 4'd9, 5'd0}; cmd_command = 3'd2; cmd_src = 1'b1; gnt_delay = 20;
        repeat (2) @(negedge clk);
        cmd_command = 3'd0;
        nresp = 0; nwr = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
            if (|meta_we) nwr++;
        end
        check("abort_resp", nresp, 0);
        check("abort_write", nwr, 0);
        check("abort_arr_req", arr_req, 1'b0);
        txn({23'h00AA, 4'd9, 5'd0}, 3'd1, 1'b1, 1);

        // Reset arrives while the metadata write is on the bus
        v[0] = mk(2'b11, 23'h0BEE); v[1] = '0; v[2] = '0; v[3] = '0;
        load_set(4'd5, v);
        cmd_addr = {23'h0BEE, 4'd5, 5'd0}; cmd_command = 3'd1; cmd_src = 1'b1; gnt_delay = 0;
        repeat (3) @(negedge clk);
        check("rst_case_resp", resp_valid, 1'b1);
        @(negedge clk);
        check("rst_case_update", meta_we, 4'b0001);
        rst = 1'b1; cmd_command = 3'd0;
        #1;
        check("rst_no_partial_we", meta_we, 4'b0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_arr_req", arr_req, 1'b0);
        check("rst_arr_set", arr_set, 4'd0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_hit", resp_hit, 1'b0);
        check("rst_meta_we", meta_we, 4'b0);
        repeat (2) @(negedge clk);
        check("rst_line_kept", mem_meta[5][0], exp_meta[5][0]);
        txn({23'h0BEE, 4'd5, 5'd0}, 3'd1, 1'b1, 0);

        // Randomized snoops over freshly loaded sets
        for (int i = 0; i < 40; i++) begin
            rs = 4'($urandom_range(0, 15));
            for (int w = 0; w < NUM_WAYS; w++)
                v[w] = mk(st_pool[$urandom_range(0, 2)], pool[$urandom_range(0, 2)]);
            load_set(rs, v);
            txn({pool[$urandom_range(0, 2)], rs, 5'($urandom())}, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
